// File: rtl/muldiv_hilo_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architected HI/LO registers.
// Optional macro MULDIV_DIV0_EN: short-circuit divide-by-zero and expose a sticky div0 flag.
module muldiv_hilo_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    input  logic             mf_req,
    input  logic             mf_sel,
    output logic [WIDTH-1:0] mf_data,
    output logic             busy,
    output logic             stall,
    output logic             done
`ifdef MULDIV_DIV0_EN
    ,
    output logic             div0
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t state, state_next;

    logic [CNT_W-1:0]   count;
    logic [WIDTH-1:0]   acc_hi, acc_lo, operand;
    logic [WIDTH-1:0]   hi, lo;
    logic               op_div;
    logic               neg_q, neg_r;

    logic               is_div_in, signed_in, launch, zero_div_in;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     add_sum, rem_shift, rem_diff;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quot_fixed, rem_fixed;

    assign is_div_in = op[1];
    assign signed_in = ~op[0];
    assign abs_a     = (signed_in && src_a[WIDTH-1]) ? -src_a : src_a;
    assign abs_b     = (signed_in && src_b[WIDTH-1]) ? -src_b : src_b;
    assign launch    = (state == IDLE) && start && !flush;

`ifdef MULDIV_DIV0_EN
    logic zero_div;
    assign zero_div_in = is_div_in && (src_b == '0);
`else
    assign zero_div_in = 1'b0;
`endif

    // Multiply: conditional add of the multiplicand into the upper half, then shift the pair right.
    assign add_sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
    // Divide: partial remainder picks up the next dividend bit; a borrow means the quotient bit is 0.
    assign rem_shift  = {acc_hi, acc_lo[WIDTH-1]};
    assign rem_diff   = rem_shift - {1'b0, operand};

    assign prod_fixed = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    assign quot_fixed = neg_q ? -acc_lo : acc_lo;
    assign rem_fixed  = neg_r ? -acc_hi : acc_hi;

    assign busy    = (state != IDLE);
    assign stall   = busy & (start | mf_req);
    assign mf_data = mf_sel ? hi : lo;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (launch) state_next = zero_div_in ? FIX : RUN;
            RUN: begin
                if (flush)                   state_next = IDLE;
                else if (count == LAST_STEP) state_next = FIX;
            end
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            operand  <= '0;
            op_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
`ifdef MULDIV_DIV0_EN
            zero_div <= 1'b0;
            div0     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch) begin
                        count  <= '0;
                        op_div <= is_div_in;
                        neg_q  <= signed_in & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                        neg_r  <= signed_in & is_div_in & src_a[WIDTH-1];
                        acc_hi <= '0;
                        if (is_div_in) begin
                            acc_lo  <= abs_a;
                            operand <= abs_b;
                        end else begin
                            acc_lo  <= abs_b;
                            operand <= abs_a;
                        end
`ifdef MULDIV_DIV0_EN
                        zero_div <= zero_div_in;
                        // Zero divisor: preload the final result so FIX writes it unmodified.
                        if (zero_div_in) begin
                            acc_hi <= src_a;
                            acc_lo <= '1;
                            neg_q  <= 1'b0;
                            neg_r  <= 1'b0;
                        end
`endif
                    end
                end
                RUN: begin
                    if (!flush) begin
                        count <= count + CNT_W'(1);
                        if (op_div) begin
                            if (!rem_diff[WIDTH]) begin
                                acc_hi <= rem_diff[WIDTH-1:0];
                                acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                            end else begin
                                acc_hi <= rem_shift[WIDTH-1:0];
                                acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                            end
                        end else begin
                            acc_hi <= add_sum[WIDTH:1];
                            acc_lo <= {add_sum[0], acc_lo[WIDTH-1:1]};
                        end
                    end
                end
                FIX: begin
                    if (!flush) begin
                        if (op_div) begin
                            hi <= rem_fixed;
                            lo <= quot_fixed;
                        end else begin
                            {hi, lo} <= prod_fixed;
                        end
                        done <= 1'b1;
`ifdef MULDIV_DIV0_EN
                        if (zero_div) div0 <= 1'b1;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
